// File: rtl/c3lib_vecsync_rr_arb.sv
// c3lib_vecsync_rr_arb: round-robin arbiter launching held {toggle,id,data} words into one vecsync port (ports clk,rst,req,req_data,gnt,busy,sync_data); define C3LIB_VECSYNC_ARB_PRIO0_EN for strict requester-0 priority
module c3lib_vecsync_rr_arb #(
  parameter int NREQ      = 4,
  parameter int DWIDTH    = 8,
  parameter int HOLD_CYC  = 8,
  parameter int RESET_VAL = 0,
  localparam int IDW      = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DWIDTH-1:0]   req_data,
  output logic [NREQ-1:0]          gnt,
  output logic                     busy,
  output logic [IDW+DWIDTH:0]      sync_data
);
  localparam int CW = $clog2(HOLD_CYC);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [IDW-1:0] ptr, rr_win, win, idx;
  logic [DWIDTH-1:0] dat [NREQ];
  logic found, launch, upd;
  always_comb begin
    for (int i = 0; i < NREQ; i++) dat[i] = req_data[i*DWIDTH +: DWIDTH];
  end
  always_comb begin
    rr_win = ptr;
    idx = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k >= NREQ) ? IDW'(int'(ptr) + k - NREQ) : IDW'(int'(ptr) + k);
      if (!found && req[idx]) begin
        found = 1'b1;
        rr_win = idx;
      end
    end
  end
  always_comb state_nxt = (state == IDLE) ? (|req ? HOLD : IDLE) : (cnt == '0 ? IDLE : HOLD);
  always_comb begin
    launch = (state == IDLE) && |req;
`ifdef C3LIB_VECSYNC_ARB_PRIO0_EN
    win = req[0] ? '0 : rr_win;
    upd = !req[0];
`else
    win = rr_win;
    upd = 1'b1;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      ptr <= '0;
      gnt <= '0;
      busy <= 1'b0;
      sync_data <= {1'b0, {IDW{1'b0}}, (RESET_VAL == 0) ? {DWIDTH{1'b0}} : {DWIDTH{1'b1}}};
    end else begin
      state <= state_nxt;
      gnt <= launch ? NREQ'(1) << win : '0;
      busy <= launch | (state == HOLD && cnt != '0);
      cnt <= launch ? CW'(HOLD_CYC - 1) : (state == HOLD && cnt != '0) ? cnt - 1'b1 : cnt;
      if (launch) begin
        sync_data <= {~sync_data[IDW+DWIDTH], win, dat[win]};
        if (upd) ptr <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_c3lib_vecsync_rr_arb.sv
// tb_c3lib_vecsync_rr_arb: scoreboard bench with a cycle-counting reference model for c3lib_vecsync_rr_arb (C3LIB_VECSYNC_ARB_PRIO0_EN aware)
module tb_c3lib_vecsync_rr_arb;
  localparam int NREQ = 4, DW = 8, HC = 8, IDW = 2, SW = 1 + IDW + DW;
  logic clk = 1'b0, rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0] gnt;
  logic busy;
  logic [SW-1:0] sync_data;
  c3lib_vecsync_rr_arb #(.NREQ(NREQ), .DWIDTH(DW), .HOLD_CYC(HC), .RESET_VAL(0)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .gnt(gnt), .busy(busy), .sync_data(sync_data));
  always #5 clk = ~clk;
  int vec = 0, err = 0;
  bit chk = 1'b0;
  int m_left = 0, m_start = 0, w;
  bit upd;
  logic [SW-1:0] exp_sd = '0;
  logic exp_busy = 1'b0;
  logic [NREQ-1:0] exp_g;
  logic [NREQ+SW-1:0] q[$];
  logic [NREQ+SW-1:0] e;
  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_left = 0;
      m_start = 0;
      exp_sd = '0;
      exp_busy = 1'b0;
      q.delete();
    end else if (m_left > 0) begin
      m_left--;
      exp_busy = (m_left > 0);
    end else if (req != '0) begin
      w = -1;
      upd = 1'b1;
`ifdef C3LIB_VECSYNC_ARB_PRIO0_EN
      if (req[0]) begin
        w = 0;
        upd = 1'b0;
      end
`endif
      for (int k = 0; k < NREQ && w < 0; k++) if (req[(m_start + k) % NREQ]) w = (m_start + k) % NREQ;
      exp_sd = {~exp_sd[SW-1], IDW'(w), DW'(req_data >> (w * DW))};
      exp_g = NREQ'(1) << w;
      q.push_back({exp_g, exp_sd});
      m_left = HC;
      exp_busy = 1'b1;
      if (upd) m_start = (w + 1) % NREQ;
    end
  end
  initial forever begin
    @(negedge clk);
    if (chk) begin
      cmp("busy", 32'(busy), 32'(exp_busy));
      cmp("sync_data", 32'(sync_data), 32'(exp_sd));
      if (gnt != '0 || q.size() != 0) begin
        if (q.size() == 0) cmp("spurious_gnt", 32'(gnt), 32'd0);
        else begin
          e = q.pop_front();
          cmp("gnt", 32'(gnt), 32'(e[NREQ+SW-1:SW]));
          cmp("gnt_word", 32'(sync_data), 32'(e[SW-1:0]));
        end
      end
    end
  end
  initial begin
    @(posedge clk);
    #1 chk = 1'b1;
    cmp("reset_sync_data", 32'(sync_data), 32'd0);
    cmp("reset_gnt", 32'(gnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    cmp("idle_sync_data", 32'(sync_data), 32'd0);
    req_data[23:16] = 8'hA5;
    req = 4'b0100;
    @(negedge clk);
    cmp("a5_gnt", 32'(gnt), 32'h4);
    cmp("a5_word", 32'(sync_data), 32'h6A5);
    req = '0;
    repeat (12) @(negedge clk);
    req = 4'b1111;
    for (int c = 0; c < 8 * (HC + 1); c++) begin
      req_data = {$urandom};
      @(negedge clk);
    end
    req = '0;
    repeat (12) @(negedge clk);
    req_data[7:0] = 8'h3C;
    req = 4'b0001;
    repeat (40) @(negedge clk);
    req = 4'b1111;
    @(negedge clk);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cmp("abort_busy", 32'(busy), 32'd0);
    cmp("abort_sync_data", 32'(sync_data), 32'd0);
    @(negedge clk);
    cmp("post_abort_gnt", 32'(gnt), 32'h1);
    repeat (20) @(negedge clk);
    for (int c = 0; c < 3000; c++) begin
      req = NREQ'($urandom);
      req_data = {$urandom};
      rst = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    req = '0;
    repeat (12) @(negedge clk);
    cmp("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
